// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor with 2-bit saturating counters.
// IF looks up the table by fetch PC. EX resolves the branch, detects a
// misprediction, supplies the redirect PC and trains the table.
module branch_predictor #(
    parameter int unsigned INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_br_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] miss_count
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W   = 32 - INDEX_BITS - 2;
    localparam int unsigned CTR_W   = 2;
    localparam logic [31:0] CNT_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_MIN  = '0;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(2);

    logic                   valid_q  [ENTRIES];
    logic [TAG_W-1:0]       tag_q    [ENTRIES];
    logic [31:0]            target_q [ENTRIES];
    logic [CTR_W-1:0]       ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0]  if_idx;
    logic [TAG_W-1:0]       if_tag;
    logic [INDEX_BITS-1:0]  ex_idx;
    logic [TAG_W-1:0]       ex_tag;
    logic                   if_hit;
    logic                   ex_hit;
    logic                   target_wrong;

    // Index and tag fields; pc[1:0] takes no part in either.
    assign if_idx = if_pc[INDEX_BITS+1:2];
    assign if_tag = if_pc[31:INDEX_BITS+2];
    assign ex_idx = ex_pc[INDEX_BITS+1:2];
    assign ex_tag = ex_pc[31:INDEX_BITS+2];

    // Fetch-side lookup from registered table state; no bypass from training.
    always_comb begin
        if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = if_hit && ctr_q[if_idx][CTR_W-1];
        pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;
    end

    // EX-side resolution: compare the actual outcome with the carried prediction.
    always_comb begin
        ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        target_wrong = ex_taken && ex_pred_taken && (ex_target != ex_pred_target);
        mispredict   = !rst && ex_br_valid &&
                       ((ex_taken != ex_pred_taken) || target_wrong);
        redirect_pc  = (ex_br_valid && ex_taken) ? ex_target : ex_pc + 32'd4;
    end

    // Table training: counters move on hits, taken misses allocate weakly taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[INDEX_BITS'(i)]  <= 1'b0;
                tag_q[INDEX_BITS'(i)]    <= '0;
                target_q[INDEX_BITS'(i)] <= '0;
                ctr_q[INDEX_BITS'(i)]    <= '0;
            end
        end else if (ex_br_valid) begin
            if (ex_hit) begin
                if (ex_taken) begin
                    if (ctr_q[ex_idx] != CTR_MAX) begin
                        ctr_q[ex_idx] <= ctr_q[ex_idx] + CTR_W'(1);
                    end
                    target_q[ex_idx] <= ex_target;
                end else if (ctr_q[ex_idx] != CTR_MIN) begin
                    ctr_q[ex_idx] <= ctr_q[ex_idx] - CTR_W'(1);
                end
            end else if (ex_taken) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target;
                ctr_q[ex_idx]    <= CTR_WEAK;
            end
        end
    end

    // Saturating event counters for resolved branches and mispredictions.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count   <= '0;
            miss_count <= '0;
        end else begin
            if (ex_br_valid && (br_count != CNT_MAX)) begin
                br_count <= br_count + 32'd1;
            end
            if (mispredict && (miss_count != CNT_MAX)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

endmodule
